// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: FSM states, word width, request payload and error causes.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CONFLICT = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_ALIGN    = 2'd3
  } err_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with write enable; read port register holds until the next enabled read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              re,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Read register: clear wins, otherwise load only on an enabled read.
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (re) q <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for a multicycle CPU control section.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects accesses with addr[1:0] != 2'b00.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_ready,
  output logic              addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  req_t              cap;

  req_t              live_c;
  req_t              cur_c;
  err_t              cause_c;
  logic              accept_c;
  logic              go_resp_c;
  logic              rd_en_c;
  logic              clr_c;
  logic              we_c;

  assign live_c = '{rd: MemRead, wr: MemWrite, addr: addr, wdata: wdata};

  // In IDLE the live request is the access being judged (needed when there are no wait states).
  assign cur_c = (state == IDLE) ? live_c : cap;

  // Rejection cause of the access currently in flight.
  always_comb begin
    cause_c = ERR_NONE;
    if (cur_c.rd && cur_c.wr)
      cause_c = ERR_CONFLICT;
    else if ({2'b00, cur_c.addr[WORD_W-1:2]} >= WORD_W'(DEPTH))
      cause_c = ERR_RANGE;
`ifdef MEM_ALIGN_CHECK_EN
    else if (cur_c.addr[1:0] != 2'b00)
      cause_c = ERR_ALIGN;
`endif
  end

`ifndef MEM_ALIGN_CHECK_EN
  logic unused_align_bits;
  assign unused_align_bits = ^cur_c.addr[1:0];
`endif

  assign accept_c  = (state == IDLE) && (MemRead || MemWrite);
  assign go_resp_c = (accept_c && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == CNT_W'(1)));

  // Read data is loaded on the edge entering RESP so it is valid alongside mem_ready.
  assign rd_en_c = reset && go_resp_c && cur_c.rd && (cause_c == ERR_NONE);
  assign clr_c   = !reset || (go_resp_c && (cause_c == ERR_RANGE));
  assign we_c    = reset && (state == RESP) && cur_c.wr && (cause_c == ERR_NONE);

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .clr   (clr_c),
    .re    (rd_en_c),
    .we    (we_c),
    .idx   (cur_c.addr[AW+1:2]),
    .wdata (cur_c.wdata),
    .q     (rdata)
  );

  // Control FSM with wait counter, captured request and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      mem_ready <= go_resp_c;
      addr_err  <= go_resp_c && (cause_c != ERR_NONE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            cap <= live_c;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
